// File: rtl/full_adder.sv
// One-bit full adder: the single arithmetic cell that serial_adder reuses every cycle.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ c_in;
  assign carry = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial adder: one full_adder is fed one LSB-first bit pair per cycle and the
// carry is looped back through a register; {c_out, sum} = a + b + c_in after WIDTH cycles.
module serial_adder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   a_sh_q, a_sh_d;
  logic [WIDTH-1:0]   b_sh_q, b_sh_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               c_out_q, c_out_d;

  logic               fa_sum;
  logic               fa_carry;
  logic [WIDTH-1:0]   acc_shift;

  full_adder fa (
    .a     (a_sh_q[0]),
    .b     (b_sh_q[0]),
    .c_in  (carry_q),
    .sum   (fa_sum),
    .carry (fa_carry)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts bit 0 sits at the LSB.
  assign acc_shift = (acc_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      acc_q   <= acc_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    c_out_d = c_out_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        acc_d   = acc_shift;
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          sum_d   = acc_shift;
          c_out_d = fa_carry;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit and a 1-bit instance on a shared clock and reset.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       start8 = 1'b0;
  logic [7:0] a8 = '0;
  logic [7:0] b8 = '0;
  logic       cin8 = 1'b0;
  logic       busy8, done8, cout8;
  logic [7:0] sum8;

  logic       start1 = 1'b0;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic       cin1 = 1'b0;
  logic       busy1, done1, cout1;
  logic [0:0] sum1;

  int n_vec = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8)
  );

  serial_adder #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts one 8-bit addition; lat counts edges from the accepting edge to done.
  task automatic add8(input logic [7:0] aa, input logic [7:0] bb, input logic cc,
                      output int lat, output int bcnt, output int overlap);
    @(negedge clk);
    a8 = aa; b8 = bb; cin8 = cc; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = 1; bcnt = 0; overlap = 0;
    while (!done8 && lat < 40) begin
      if (busy8) bcnt++;
      tick();
      lat++;
    end
    if (busy8 && done8) overlap = 1;
  endtask

  task automatic add1(input logic aa, input logic bb, input logic cc, output int lat);
    @(negedge clk);
    a1 = aa; b1 = bb; cin1 = cc; start1 = 1'b1;
    tick();
    start1 = 1'b0;
    lat = 1;
    while (!done1 && lat < 20) begin
      tick();
      lat++;
    end
  endtask

  initial begin
    int lat, bcnt, ovl, dn;
    logic [1:0] r1;

    #1;
    chk("rst_busy8", 32'(busy8), 32'd0);
    chk("rst_done8", 32'(done8), 32'd0);
    chk("rst_sum8",  32'(sum8),  32'd0);
    chk("rst_cout8", 32'(cout8), 32'd0);
    chk("rst_sum1",  32'({cout1, sum1}), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // 5A + 3C
    add8(8'h5A, 8'h3C, 1'b0, lat, bcnt, ovl);
    chk("t1_latency", 32'(lat), 32'd9);
    chk("t1_busy_cycles", 32'(bcnt), 32'd8);
    chk("t1_overlap", 32'(ovl), 32'd0);
    chk("t1_sum", 32'(sum8), 32'h96);
    chk("t1_cout", 32'(cout8), 32'd0);
    tick();
    chk("t1_done_pulse", 32'(done8), 32'd0);
    chk("t1_idle_busy", 32'(busy8), 32'd0);

    // FF + 01
    add8(8'hFF, 8'h01, 1'b0, lat, bcnt, ovl);
    chk("t2_latency", 32'(lat), 32'd9);
    chk("t2_sum", 32'(sum8), 32'h00);
    chk("t2_cout", 32'(cout8), 32'd1);

    // FF + 00 + carry-in
    add8(8'hFF, 8'h00, 1'b1, lat, bcnt, ovl);
    chk("t3_sum", 32'(sum8), 32'h00);
    chk("t3_cout", 32'(cout8), 32'd1);

    // 10 + 20 with start re-asserted during RUN and DONE
    @(negedge clk);
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    dn = 0;
    tick();
    tick();
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("t4_busy_run3", 32'(busy8), 32'd1);
    chk("t4_sum_stable", 32'(sum8), 32'h00);
    for (int i = 0; i < 5; i++) begin
      dn += int'(done8);
      tick();
    end
    chk("t4_done", 32'(done8), 32'd1);
    chk("t4_sum", 32'(sum8), 32'h30);
    chk("t4_cout", 32'(cout8), 32'd0);
    dn += int'(done8);
    a8 = 8'h07; b8 = 8'h08; cin8 = 1'b0; start8 = 1'b1;
    tick();
    chk("t4_done_gone", 32'(done8), 32'd0);
    chk("t4_idle_after_done", 32'(busy8), 32'd0);
    chk("t4_sum_held", 32'(sum8), 32'h30);
    dn += int'(done8);
    chk("t4_single_done", 32'(dn), 32'd1);
    tick();
    start8 = 1'b0;
    chk("t4_restart_busy", 32'(busy8), 32'd1);
    lat = 0;
    while (!done8 && lat < 20) begin
      tick();
      lat++;
    end
    chk("t4_restart_lat", 32'(lat), 32'd8);
    chk("t4_restart_sum", 32'(sum8), 32'h0F);

    // AA + 55 aborted by reset mid-RUN
    tick();
    @(negedge clk);
    a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    repeat (4) tick();
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_rst_busy", 32'(busy8), 32'd0);
    chk("t5_rst_done", 32'(done8), 32'd0);
    chk("t5_rst_sum", 32'(sum8), 32'd0);
    chk("t5_rst_cout", 32'(cout8), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    dn = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      dn += int'(done8) + int'(busy8);
    end
    chk("t5_no_activity", 32'(dn), 32'd0);
    add8(8'h01, 8'h01, 1'b0, lat, bcnt, ovl);
    chk("t5_post_lat", 32'(lat), 32'd9);
    chk("t5_post_sum", 32'(sum8), 32'h02);
    chk("t5_post_cout", 32'(cout8), 32'd0);

    // WIDTH=1: all input combinations
    for (int v = 0; v < 8; v++) begin
      add1(v[2], v[1], v[0], lat);
      r1 = 2'(v[2]) + 2'(v[1]) + 2'(v[0]);
      chk($sformatf("w1_lat_%0d", v), 32'(lat), 32'd2);
      chk($sformatf("w1_res_%0d", v), 32'({cout1, sum1}), 32'(r1));
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that reuses one `full_adder` instance over many clock cycles instead of chaining WIDTH copies. It captures two WIDTH-bit operands and a carry-in on a start strobe, then feeds one bit pair per cycle, LSB first, into the `full_adder`. The carry-out is registered and fed back as the next cycle's `c_in`. The block sits directly upstream of `full_adder`: it supplies its `a`/`b`/`c_in` and consumes its `sum`/`carry`. It is the sequential counterpart of the combinational adder chain.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range ≥ 1.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to begin an addition; sampled on rising edge, honoured only in IDLE.
- `a`  input  WIDTH  operand A; sampled on the accepting edge only.
- `b`  input  WIDTH  operand B; sampled on the accepting edge only.
- `c_in`  input  1  initial carry; sampled on the accepting edge only.
- `busy`  output  1  high while bits are being processed (RUN state).
- `done`  output  1  single-cycle pulse: `sum`/`c_out` just updated.
- `sum`  output  WIDTH  registered result; holds last completed value.
- `c_out`  output  1  registered final carry; holds last completed value.

## Operation
- State machine with three states: IDLE, RUN, DONE.
- **IDLE, `start`=1 on an edge:**
  - load A and B shift registers from `a`/`b`;
  - load the carry register from `c_in`;
  - clear the bit counter;
  - go to RUN.
- **IDLE, `start`=0:** stay in IDLE.
- **RUN, each edge:**
  - `full_adder` inputs are `a_sh[0]`, `b_sh[0]` and the carry register.
  - Its `sum` shifts into the MSB of the accumulating shift register, which shifts right.
  - Its `carry` loads the carry register.
  - A and B shift right by one.
  - The counter increments.
- **RUN, on the edge processing bit WIDTH-1:**
  - copy the completed accumulator into `sum` and the carry-out into `c_out`;
  - go to DONE.
- **DONE:** `done`=1 for exactly this cycle; next edge returns to IDLE unconditionally.
- **`start` outside IDLE** (RUN or DONE) is ignored, with no effect on operands or state. A new request is accepted one cycle after `done`, at the earliest.
- **Arithmetic:** `{c_out, sum}` = `a + b + c_in`, exact, unsigned, WIDTH+1 bits; no overflow flag.
- **Counter width:** `$clog2(WIDTH)`, minimum 1 bit.
- **WIDTH=1:** RUN lasts one cycle.
- **Output stability:** `sum`/`c_out` never show partial results; they change only on the completion edge.
- **Reset (`rst_n`=0), any time including mid-RUN:** immediately, without waiting for a clock edge:
  - state → IDLE;
  - `busy`=0, `done`=0, `sum`=0, `c_out`=0;
  - shift registers, carry register and counter cleared;
  - an in-flight operation is discarded.
- **Reset release:** first accept possible on the first edge with `rst_n`=1 and `start`=1.

## Timing
- Edge E0 accepts `start`.
- `busy` is high from after E0 through the cycle before E(WIDTH); the block is in RUN for exactly WIDTH cycles.
- Edge E(WIDTH) updates `sum`/`c_out` and enters DONE.
- `done` is high between E(WIDTH) and E(WIDTH+1).
- Start-to-`done` latency: WIDTH+1 edges; throughput: one addition per WIDTH+2 cycles.
- `busy` and `done` are never high simultaneously. Both are registered (state-decoded), not driven combinationally from inputs.
- Critical path: one `full_adder` plus the carry-register setup, independent of WIDTH.

## Structure
- No shared package. State encodings are local parameters of this module; WIDTH is the only tunable.
- One sub-module: the existing `full_adder`, instantiated once, named `fa`, with all four ports connected.
- No other hierarchy.

## Test plan
- WIDTH=8, `a`=8'h5A, `b`=8'h3C, `c_in`=0, `start` pulse → `done` 9 edges later:
  - `sum`=8'h96, `c_out`=0;
  - `busy` high exactly 8 cycles.
- WIDTH=8, `a`=8'hFF, `b`=8'h01, `c_in`=0 → `sum`=8'h00, `c_out`=1.
- WIDTH=8, `a`=8'hFF, `b`=8'h00, `c_in`=1 → `sum`=8'h00, `c_out`=1.
- Start 8'h10+8'h20; assert `start` with other operands at RUN cycle 3 and again during DONE:
  - result is 8'h30;
  - a single `done` pulse;
  - `start` held high in the following IDLE cycle begins a new addition.
- Start 8'hAA+8'h55; pull `rst_n` low at RUN cycle 4, between edges:
  - all outputs are 0 before the next edge;
  - no `done` occurs;
  - after release, 8'h01+8'h01 → `sum`=8'h02.
- WIDTH=1 instance, all 8 combinations of `a`/`b`/`c_in`:
  - `{c_out, sum}` = `a+b+c_in`;
  - `done` 2 edges after `start`.
